// File: rtl/addsub_arbiter_pkg.sv
// addsub_arbiter_pkg: shared FSM states, default width and round-robin grant helper
package addsub_arbiter_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;
  function automatic logic rr_grant(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction
endpackage

// File: rtl/addsub_arbiter_adder_subtractor_unit.sv
// adder_subtractor_unit: combinational A+B / A-B with carry-out and two's-complement overflow
module adder_subtractor_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mode,
  output logic [WIDTH-1:0] S,
  output logic             Carry,
  output logic             V
);
  logic [WIDTH-1:0] bx;
  assign bx = mode ? ~B : B;
  assign {Carry, S} = {1'b0, A} + {1'b0, bx} + {{WIDTH{1'b0}}, mode};
  // same-sign operands producing an opposite-sign result is exactly carry-in(MSB) ^ carry-out
  assign V = (A[WIDTH-1] == bx[WIDTH-1]) && (S[WIDTH-1] != A[WIDTH-1]);
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbitration of two requesters onto one registered adder-subtractor
module addsub_arbiter
  import addsub_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             sub0,
  input  logic             sub1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             valid,
  output logic             owner,
  output logic             busy
);
  state_t state, next;
  logic last, sel, grant, opsub, s_carry, s_ovf;
  logic [WIDTH-1:0] opa, opb, s_sum;
  always_comb begin
    next = state == ST_IDLE ? ((req0 || req1) ? ST_EXEC : ST_IDLE)
         : state == ST_EXEC ? ST_DONE : ST_IDLE;
    grant = rr_grant(req0, req1, last);
  end
  assign valid = state == ST_DONE;
  assign ack0 = valid && !owner;
  assign ack1 = valid && owner;
  assign busy = state != ST_IDLE;
  adder_subtractor_unit #(.WIDTH(WIDTH)) u_alu (
    .A(opa),
    .B(opb),
    .mode(opsub),
    .S(s_sum),
    .Carry(s_carry),
    .V(s_ovf)
  );
  // owner is published with the result so it holds the last served index until the next DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      last <= 1'b1;
      sel <= 1'b0;
      opa <= '0;
      opb <= '0;
      opsub <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      ovf <= 1'b0;
      owner <= 1'b0;
    end else begin
      state <= next;
      if (state == ST_IDLE && (req0 || req1)) begin
        sel <= grant;
        opa <= grant ? a1 : a0;
        opb <= grant ? b1 : b0;
        opsub <= grant ? sub1 : sub0;
      end
      if (state == ST_EXEC) begin
        result <= s_sum;
        carry <= s_carry;
        ovf <= s_ovf;
        owner <= sel;
      end
      if (state == ST_DONE) last <= owner;
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed self-checking bench with hand-computed expectations
module tb_addsub_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, sub0 = 1'b0, sub1 = 1'b0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic ack0, ack1, carry, ovf, valid, owner, busy;
  logic [3:0] result;
  int n_cmp = 0, n_err = 0;
  addsub_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .sub0(sub0), .sub1(sub1),
    .ack0(ack0), .ack1(ack1), .result(result), .carry(carry), .ovf(ovf),
    .valid(valid), .owner(owner), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic check_out(input string tag, input logic k0, input logic k1, input logic [3:0] r,
                           input logic c, input logic v, input logic o, input logic b);
    check({tag, ".ack0"}, ack0, k0);
    check({tag, ".ack1"}, ack1, k1);
    check({tag, ".valid"}, valid, k0 | k1);
    check({tag, ".result"}, result, r);
    check({tag, ".carry"}, carry, c);
    check({tag, ".ovf"}, ovf, v);
    check({tag, ".owner"}, owner, o);
    check({tag, ".busy"}, busy, b);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      check("mon.onehot_ack", ack0 & ack1, 1'b0);
      check("mon.valid_ack", valid, ack0 | ack1);
      if (valid) check("mon.busy_in_done", busy, 1'b1);
    end
  end
  initial begin
    #2;
    check_out("reset", 0, 0, 4'h0, 0, 0, 0, 0);
    step;
    step;
    reset = 1'b0;
    step;
    check_out("idle_noreq", 0, 0, 4'h0, 0, 0, 0, 0);
    req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0101; sub0 = 1'b0;
    step;
    check_out("t1.exec", 0, 0, 4'h0, 0, 0, 0, 1);
    step;
    check_out("t1.done", 1, 0, 4'b1000, 0, 1, 0, 1);
    req0 = 1'b0;
    step;
    check_out("t1.hold", 0, 0, 4'b1000, 0, 1, 0, 0);
    req1 = 1'b1; a1 = 4'b0101; b1 = 4'b0111; sub1 = 1'b1;
    step;
    check_out("t2.exec", 0, 0, 4'b1000, 0, 1, 0, 1);
    step;
    check_out("t2.done", 0, 1, 4'b1110, 0, 0, 1, 1);
    req1 = 1'b0;
    step;
    check_out("t2.hold", 0, 0, 4'b1110, 0, 0, 1, 0);
    reset = 1'b1;
    #1;
    check_out("t3.reset", 0, 0, 4'h0, 0, 0, 0, 0);
    step;
    reset = 1'b0;
    req0 = 1'b1; a0 = 4'b1111; b0 = 4'b1111; sub0 = 1'b0;
    req1 = 1'b1; a1 = 4'b0110; b1 = 4'b1000; sub1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      step;
      check_out($sformatf("t3.op%0d", i), i % 2 == 0, i % 2 == 1, 4'b1110,
                i % 2 == 0, i % 2 == 1, i % 2 == 1, 1);
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      step;
    end
    check_out("t3.idle", 0, 0, 4'b1110, 0, 1, 1, 0);
    req0 = 1'b1; a0 = 4'b0010; b0 = 4'b0011; sub0 = 1'b0;
    step;
    a0 = 4'b1001; b0 = 4'b0111; sub0 = 1'b1; req0 = 1'b0;
    step;
    check_out("t4.drop_done", 1, 0, 4'b0101, 0, 0, 0, 1);
    step;
    check_out("t4.idle", 0, 0, 4'b0101, 0, 0, 0, 0);
    req1 = 1'b1; a1 = 4'b0001; b1 = 4'b0001; sub1 = 1'b0;
    step;
    check("t5.in_exec", busy, 1'b1);
    reset = 1'b1;
    req1 = 1'b0;
    #1;
    check_out("t5.async_reset", 0, 0, 4'h0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    step;
    check_out("t5.no_ack_a", 0, 0, 4'h0, 0, 0, 0, 0);
    step;
    check_out("t5.no_ack_b", 0, 0, 4'h0, 0, 0, 0, 0);
    req0 = 1'b1; a0 = 4'b0100; b0 = 4'b0001; sub0 = 1'b1;
    req1 = 1'b1; a1 = 4'b0001; b1 = 4'b0001; sub1 = 1'b0;
    step;
    step;
    check_out("t5.tie_after_reset", 1, 0, 4'b0011, 1, 0, 0, 1);
    req0 = 1'b0;
    step;
    step;
    step;
    check_out("t5.req1_next", 0, 1, 4'b0010, 0, 0, 1, 1);
    req1 = 1'b0;
    step;
    check_out("t5.idle", 0, 0, 4'b0010, 0, 0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
